// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register/word aliases, controller state encoding and
// the register-match helper used by hazard detection.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // $zero is never a real dependency, so it never matches.
    function automatic logic reg_dep(input regbits_t producer, input regbits_t consumer);
        return (producer != '0) && (producer == consumer);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational hazard sources: load-use dependency between EX and ID, and
// a MEM-stage access still waiting on the data cache.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     dhit,
    input  logic     exmem_dREN,
    input  logic     exmem_dWEN,
    input  logic     idex_dREN,
    input  regbits_t idex_rt,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    input  logic     ifid_uses_rt,
    output logic     load_use,
    output logic     mem_busy
);

    assign mem_busy = (exmem_dREN | exmem_dWEN) & ~dhit;

    assign load_use = idex_dREN &
                      (reg_dep(idex_rt, ifid_rs) | (ifid_uses_rt & reg_dep(idex_rt, ifid_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: per-cycle latch enables and flushes, halt
// drain tracking, and saturating stall/flush counters.
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             idex_dREN,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_jump,
    input  logic             ifid_halt,
    input  logic             ex_redirect,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state, next_state;
    logic        load_use, mem_busy;

    hazard_detect u_hazard (
        .dhit         (dhit),
        .exmem_dREN   (exmem_dREN),
        .exmem_dWEN   (exmem_dWEN),
        .idex_dREN    (idex_dREN),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .load_use     (load_use),
        .mem_busy     (mem_busy)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    // Priority mux: first matching condition owns the strobes.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (state == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (state == DRAIN) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end else if (ifid_jump) begin
            ifid_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (memwb_halt)
                    next_state = HALTED;
                else if (ifid_halt && idex_en && !idex_flush)
                    next_state = DRAIN;
            end
            DRAIN:   if (memwb_halt) next_state = HALTED;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    assign halted = (state == HALTED);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state != HALTED) begin
            if (!pc_en && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
            if ((ifid_flush || idex_flush) && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: driver applies directed and random inputs, pushes the
// reference model's expectation; a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN;
    logic [4:0]    idex_rt, ifid_rs, ifid_rt;
    logic          ifid_uses_rt, ifid_jump, ifid_halt, ex_redirect, memwb_halt;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic          halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
        .idex_dREN(idex_dREN), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .ifid_jump(ifid_jump), .ifid_halt(ifid_halt),
        .ex_redirect(ex_redirect), .memwb_halt(memwb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        bit rst;
        bit ihit, dhit, dren, dwen, ld;
        int ld_rt, rs, rt;
        bit uses_rt, jump, halt, redir, wb_halt;
    } stim_t;

    typedef struct {
        bit [8:0] strobes;  // pc,ifid,idex,exmem,memwb en; ifid,idex,exmem,memwb flush
        bit       halted;
        int       stall, flush;
    } exp_t;

    exp_t  sbq[$];
    int    checks = 0, errors = 0;

    // Reference model: halted/draining flags and plain integer counters.
    bit    m_halted, m_drain;
    int    m_stall, m_flush;
    stim_t last_s;
    exp_t  last_e;

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit pc = 1, f = 1, d = 1, x = 1, w = 1, ff = 0, df = 0, xf = 0, wf = 0;
        bit busy = (s.dren || s.dwen) && !s.dhit;
        bit lu = s.ld && s.ld_rt != 0 && (s.ld_rt == s.rs || (s.uses_rt && s.ld_rt == s.rt));
        if (m_halted) begin pc = 0; f = 0; d = 0; x = 0; w = 0; end
        else if (busy) begin pc = 0; f = 0; d = 0; x = 0; wf = 1; end
        else if (s.redir) begin ff = 1; df = 1; end
        else if (lu) begin pc = 0; f = 0; df = 1; end
        else if (m_drain) begin pc = 0; ff = 1; end
        else if (s.jump) ff = 1;
        else if (!s.ihit) begin pc = 0; ff = 1; end
        e.strobes = {pc, f, d, x, w, ff, df, xf, wf};
        e.halted  = m_halted;
        e.stall   = m_stall;
        e.flush   = m_flush;
        return e;
    endfunction

    // Advance the model across one clock edge using the inputs applied before it.
    task automatic model_edge();
        if (last_s.rst || m_halted) return;
        if (!last_e.strobes[8]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (last_e.strobes[3] || last_e.strobes[2]) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        if (last_s.wb_halt) begin m_halted = 1; m_drain = 0; end
        else if (!m_drain && last_s.halt && last_e.strobes[6] && !last_e.strobes[2]) m_drain = 1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.ihit = 1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        @(posedge CLK);
        model_edge();
        #1;
        nRST = !s.rst; ihit = s.ihit; dhit = s.dhit;
        exmem_dREN = s.dren; exmem_dWEN = s.dwen; idex_dREN = s.ld;
        idex_rt = 5'(s.ld_rt); ifid_rs = 5'(s.rs); ifid_rt = 5'(s.rt);
        ifid_uses_rt = s.uses_rt; ifid_jump = s.jump; ifid_halt = s.halt;
        ex_redirect = s.redir; memwb_halt = s.wb_halt;
        if (s.rst) begin m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0; end
        last_s = s;
        last_e = predict(s);
        sbq.push_back(last_e);
    endtask

    task automatic do_reset();
        stim_t s = idle();
        s.rst = 1;
        step(s);
        step(s);
    endtask

    // Monitor: compare whatever the driver has queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks += 4;
                if ({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush} !== e.strobes) begin
                    errors++;
                    $display("FAIL strobes t=%0t got %b exp %b", $time,
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                         ifid_flush, idex_flush, exmem_flush, memwb_flush}, e.strobes);
                end
                if (halted !== e.halted) begin
                    errors++;
                    $display("FAIL halted t=%0t got %b exp %b", $time, halted, e.halted);
                end
                if (stall_cnt !== CW'(e.stall)) begin
                    errors++;
                    $display("FAIL stall_cnt t=%0t got %0d exp %0d", $time, stall_cnt, e.stall);
                end
                if (flush_cnt !== CW'(e.flush)) begin
                    errors++;
                    $display("FAIL flush_cnt t=%0t got %0d exp %0d", $time, flush_cnt, e.flush);
                end
            end
        end
    end

    initial begin
        stim_t s;
        nRST = 0; ihit = 1; dhit = 0; exmem_dREN = 0; exmem_dWEN = 0; idex_dREN = 0;
        idex_rt = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0; ifid_jump = 0;
        ifid_halt = 0; ex_redirect = 0; memwb_halt = 0;
        last_s = idle(); last_s.rst = 1;
        m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        last_e = predict(last_s);
        do_reset();
        repeat (3) step(idle());

        // Load-use on rs, then the same with rt=$zero.
        s = idle(); s.ld = 1; s.ld_rt = 5; s.rs = 5; step(s);
        step(idle());
        s.ld_rt = 0; s.rs = 0; step(s);
        s = idle(); s.ld = 1; s.ld_rt = 7; s.rt = 7; s.uses_rt = 1; step(s);
        step(idle());

        // Data miss for three cycles, then hit.
        s = idle(); s.dren = 1;
        repeat (3) step(s);
        s.dhit = 1; step(s);
        step(idle());

        // Redirect with load-use; redirect under a pending miss.
        s = idle(); s.redir = 1; s.ld = 1; s.ld_rt = 9; s.rs = 9; step(s);
        s = idle(); s.dwen = 1; s.redir = 1; step(s);
        s.dhit = 1; step(s);
        s = idle(); s.jump = 1; step(s);
        s = idle(); s.ihit = 0; step(s);

        // Halt drain: halt advances, redirect during drain, WB halt later.
        s = idle(); s.halt = 1; step(s);
        step(idle());
        s = idle(); s.redir = 1; step(s);
        s = idle(); s.wb_halt = 1; step(s);
        repeat (4) step(idle());
        s = idle(); s.ihit = 0; repeat (2) step(s);

        // Reset out of HALTED, then saturate the stall counter.
        do_reset();
        s = idle(); s.ihit = 0;
        repeat (20) step(s);
        do_reset();

        // Randomized traffic, with occasional resets to leave HALTED.
        for (int i = 0; i < 600; i++) begin
            s.rst     = ($urandom_range(0, 59) == 0);
            s.ihit    = ($urandom_range(0, 3) != 0);
            s.dhit    = ($urandom_range(0, 2) != 0);
            s.dren    = ($urandom_range(0, 3) == 0);
            s.dwen    = ($urandom_range(0, 5) == 0);
            s.ld      = ($urandom_range(0, 2) == 0);
            s.ld_rt   = $urandom_range(0, 3);
            s.rs      = $urandom_range(0, 3);
            s.rt      = $urandom_range(0, 3);
            s.uses_rt = $urandom_range(0, 1);
            s.jump    = ($urandom_range(0, 5) == 0);
            s.halt    = ($urandom_range(0, 19) == 0);
            s.redir   = ($urandom_range(0, 5) == 0);
            s.wb_halt = ($urandom_range(0, 39) == 0);
            step(s);
        end

        step(idle());
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge CLK);
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d exp 0", sbq.size());
        end
        @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
